// File: rtl/display_sequencer.sv
// display_sequencer: raster timing generator and pixel sequencer feeding the TMDS encoder
module display_sequencer #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int CORDW  = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             en,
    input  logic             clr_underflow,
    input  logic [7:0]       src_r,
    input  logic [7:0]       src_g,
    input  logic [7:0]       src_b,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             frame,
    output logic             active,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [15:0]      underflow_cnt
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);
    localparam logic [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic HS_ON = H_POL != 0;
    localparam logic VS_ON = V_POL != 0;

    typedef enum logic {S_OFF, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             w_eol;
    logic             w_eof;
    logic             w_act;
    logic             w_pix;
    logic             w_uf;
    logic [15:0]      w_uf_nxt;

    assign w_eol = r_sx == H_LAST;
    assign w_eof = w_eol && r_sy == V_LAST;
    assign w_act = r_sx < H_ACT && r_sy < V_ACT;
    assign w_pix = src_ready && src_valid;
    assign sx    = r_sx;
    assign sy    = r_sy;
    assign frame = r_sx == '0 && r_sy == '0;

    // raster position advances every pixel clock regardless of state
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_sx <= '0;
            r_sy <= '0;
        end else begin
            r_sx <= w_eol ? '0 : r_sx + ONE;
            if (w_eol)
                r_sy <= r_sy == V_LAST ? '0 : r_sy + ONE;
        end
    end

    // enable state, changed only on the last pixel of a frame
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)
            r_state <= S_OFF;
        else
            r_state <= w_state_nxt;
    end

    // frame-boundary transition, source handshake and saturating underflow count
    always_comb begin
        w_state_nxt = w_eof ? (en ? S_RUN : S_OFF) : r_state;
        active      = r_state == S_RUN;
        src_ready   = active && w_act;
        w_uf        = src_ready && !src_valid;
        w_uf_nxt    = clr_underflow ? {15'd0, w_uf} :
                      (w_uf && underflow_cnt != 16'hFFFF) ? underflow_cnt + 16'd1 : underflow_cnt;
    end

    // registered pixel and controls so rgb, de and syncs reach the encoder aligned
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            red           <= 8'd0;
            green         <= 8'd0;
            blue          <= 8'd0;
            de            <= 1'b0;
            hsync         <= !HS_ON;
            vsync         <= !VS_ON;
            underflow_cnt <= 16'd0;
        end else begin
            red           <= w_pix ? src_r : 8'd0;
            green         <= w_pix ? src_g : 8'd0;
            blue          <= w_pix ? src_b : 8'd0;
            de            <= src_ready;
            hsync         <= (r_sx >= HS_BEG && r_sx <= HS_END) ? HS_ON : !HS_ON;
            vsync         <= (r_sy >= VS_BEG && r_sy <= VS_END) ? VS_ON : !VS_ON;
            underflow_cnt <= w_uf_nxt;
        end
    end
endmodule
